bus2_arbiter: RTL

BUS2_ARBITER -- requirements
Module: bus2_arbiter

---
 rtl/bus2_arbiter_pkg.sv | 22 ++
 rtl/bus2_arbiter_rr.sv | 44 ++++
 rtl/bus2_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bus2_arbiter_pkg.sv
// bus2_arbiter_pkg
//   Items shared by everything that talks on bus2: default bus widths,
//   the default memory-controller delay and the C2 command encodings.
//   It has no ports. Import it with bus2_arbiter_pkg::*.
package bus2_arbiter_pkg;

    localparam int ADDR2_BUS_SIZE = 14;   // bus2 line address width
    localparam int DATA2_BUS_SIZE = 16;   // width of one bus2 data beat
    localparam int MEM_CTR_DELAY  = 100;  // command-to-first-beat delay of the controller

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_READ_LINE  = 2'd1,
        C2_WRITE_LINE = 2'd2
    } c2_cmd_e;

    // One-hot form of a 1-bit requester index.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus2_arbiter_rr.sv
// rr_arbiter2
//   Two-input round-robin arbiter with a last-grant pointer. A lone
//   request always wins. On a tie the requester that was not served last
//   wins. The pointer only moves when take_i accepts the grant. After
//   reset the pointer says "requester 1 served last", so requester 0
//   wins the first tie.
// Ports
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   req_i   : request vector, one bit per requester
//   take_i  : the current grant is being used; update the pointer
//   gnt_o   : one-hot combinational grant, zero when nobody requests
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    assign last_d = (take_i && (gnt_o != 2'b00)) ? gnt_o[1] : last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bus2_arbiter.sv
// bus2_arbiter
//   Shares bus2 between two line requesters. Each transaction runs
//   through these states:
//     IDLE : arbitrate and latch the winner's request
//     CMD  : issue the command for one cycle
//     WAIT : wait out the memory latency
//     XFER : move LINE_BEATS beats, one per cycle
//     TURN : pulse rq_done for one cycle
//   The grant is held from CMD through TURN, so a request never
//   preempts a running transaction.
// Ports
//   CLK, RESET          : clock and asynchronous active-high reset
//   rq_valid/rq_write   : per-requester request and direction (1 = write)
//   rq_addr/rq_wdata    : per-requester line address and current write beat
//   rq_grant            : one-hot owner of bus2, zero in IDLE
//   rq_wtake            : write beat consumed, so the requester advances
//   rsp_valid/rsp_data/rsp_last : read beats back to the owner
//   rq_done             : one-cycle completion pulse
//   mem_cmd/mem_addr    : command and line address toward the controller
//   mem_wdata/mem_rdata : beat data toward and from the controller
module bus2_arbiter
    import bus2_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR2_BUS_SIZE,
    parameter int DATA_W      = DATA2_BUS_SIZE,
    parameter int LINE_BEATS  = 8,
    parameter int MEM_LATENCY = MEM_CTR_DELAY
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [1:0]             rq_valid,
    input  logic [1:0]             rq_write,
    input  logic [1:0][ADDR_W-1:0] rq_addr,
    input  logic [1:0][DATA_W-1:0] rq_wdata,
    output logic [1:0]             rq_grant,
    output logic [1:0]             rq_wtake,
    output logic [1:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_last,
    output logic [1:0]             rq_done,
    output logic [1:0]             mem_cmd,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int LAT_W  = $clog2(MEM_LATENCY + 1);
    localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_XFER,
        S_TURN
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [LAT_W-1:0]    lat_q,   lat_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [1:0]          arb_gnt;
    logic                arb_take;
    logic [1:0]          owner_oh;
    c2_cmd_e             cmd_c;

    rr_arbiter2 u_rr (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .req_i  (rq_valid),
        .take_i (arb_take),
        .gnt_o  (arb_gnt)
    );

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            lat_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
        end
    end

    // Next state
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        write_d  = write_q;
        addr_d   = addr_q;
        lat_d    = lat_q;
        beat_d   = beat_q;
        arb_take = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rq_valid != 2'b00) begin
                    arb_take = 1'b1;
                    owner_d  = arb_gnt[1];
                    write_d  = rq_write[arb_gnt[1]];
                    addr_d   = rq_addr[arb_gnt[1]];
                    state_d  = S_CMD;
                end
            end
            S_CMD: begin
                // Loading LATENCY-1 and leaving WAIT on zero gives
                // exactly MEM_LATENCY WAIT cycles.
                lat_d   = LAT_W'(MEM_LATENCY - 1);
                beat_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    state_d = S_XFER;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_XFER: begin
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = S_TURN;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs. They are decoded from the state only, so reset clears
    // them in the same cycle.
    always_comb begin
        owner_oh  = req_onehot(owner_q);
        rq_grant  = 2'b00;
        rq_wtake  = 2'b00;
        rsp_valid = 2'b00;
        rsp_data  = '0;
        rsp_last  = 1'b0;
        rq_done   = 2'b00;
        cmd_c     = C2_NOP;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q != S_IDLE) begin
            rq_grant = owner_oh;
        end
        case (state_q)
            S_CMD: begin
                cmd_c    = write_q ? C2_WRITE_LINE : C2_READ_LINE;
                mem_addr = addr_q;
            end
            S_XFER: begin
                if (write_q) begin
                    rq_wtake  = owner_oh;
                    mem_wdata = rq_wdata[owner_q];
                end else begin
                    rsp_valid = owner_oh;
                    rsp_data  = mem_rdata;
                    rsp_last  = (beat_q == LAST_BEAT);
                end
            end
            S_TURN: begin
                rq_done = owner_oh;
            end
            default: begin
            end
        endcase
        mem_cmd = cmd_c;
    end

endmodule
